// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor reusing one CHUNK-bit slice, LS chunk first.
// Start/done handshake; result holds until the next accepted start.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_cfg
    $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  logic [CHUNK-1:0] ac;
  logic [CHUNK-1:0] bc;
  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             last;

  // Operands shift down so the slice always sees the current chunk at bit 0
  assign ac = ra[CHUNK-1:0];
  assign bc = rb[CHUNK-1:0];
  assign {cc, cs} = {1'b0, ac} + {1'b0, bc}
                  + {{CHUNK{1'b0}}, carry};
  assign last = (idx == IW'(STEPS - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= cs;
          carry <= cc;
          idx   <= idx + 1'b1;
          ra    <= ra >> CHUNK;
          rb    <= rb >> CHUNK;
          if (last) begin
            cout  <= cc;
            // carry into the MSB is recovered from its sum bit
            ovf   <= ac[CHUNK-1] ^ bc[CHUNK-1]
                   ^ cs[CHUNK-1] ^ cc;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: 16/4 directed+random, 3/1 and 3/3 exhaustive.
// Reference model uses plain integer arithmetic on the whole operands.
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s16, sub16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, cout16, ovf16;

  logic        s1, s3, sub3, cin3;
  logic [2:0]  a3, b3, sum1, sum3;
  logic        busy1, done1, cout1, ovf1;
  logic        busy3, done3, cout3, ovf3;

  int vecs = 0;
  int errs = 0;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .sub(sub16),
    .a(a16), .b(b16), .cin(cin16), .busy(busy16),
    .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  serial_chunk_adder #(.WIDTH(3), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .sub(sub3),
    .a(a3), .b(b3), .cin(cin3), .busy(busy1),
    .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_chunk_adder #(.WIDTH(3), .CHUNK(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .sub(sub3),
    .a(a3), .b(b3), .cin(cin3), .busy(busy3),
    .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  function automatic void model(input int w, input longint a,
                                input longint b, input bit c,
                                input bit sb, output longint s,
                                output bit co, output bit ov);
    longint m, t, sa, sbv, st, half;
    m = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    if (sb) t = a + ((~b) & m) + 1;
    else    t = a + b + longint'(c);
    s  = t & m;
    co = ((t >> w) & 1) != 0;
    sa  = (a >= half) ? a - (longint'(1) << w) : a;
    sbv = (b >= half) ? b - (longint'(1) << w) : b;
    st = sb ? sa - sbv : sa + sbv + longint'(c);
    ov = (st > half - 1) || (st < -half);
  endfunction

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input bit c, input bit sb);
    longint es;
    bit ec, eo;
    model(16, longint'(a), longint'(b), c, sb, es, ec, eo);
    a16 = a; b16 = b; cin16 = c; sub16 = sb; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    cin16 = 1'($urandom);
    sub16 = 1'($urandom);
    for (int i = 1; i <= 4; i++) begin
      vecs++;
      if (busy16 !== 1'b1 || done16 !== 1'b0) begin
        errs++;
        $display("FAIL run16_busy cyc%0d busy=%b done=%b want busy=1 done=0",
                 i, busy16, done16);
      end
      @(negedge clk);
    end
    vecs++;
    if ({done16, busy16, cout16, ovf16, sum16} !==
        {1'b1, 1'b0, ec, eo, es[15:0]}) begin
      errs++;
      $display("FAIL run16_result a=%h b=%h c=%b sub=%b got done=%b busy=%b sum=%h cout=%b ovf=%b want done=1 busy=0 sum=%h cout=%b ovf=%b",
               a, b, c, sb, done16, busy16, sum16, cout16, ovf16,
               es[15:0], ec, eo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s16 = 1'($urandom); s1 = 1'($urandom); s3 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      a3 = 3'($urandom); b3 = 3'($urandom);
      sub16 = 1'($urandom); cin16 = 1'($urandom);
      sub3 = 1'($urandom); cin3 = 1'($urandom);
      @(negedge clk);
      vecs++;
      if ({busy16, done16, cout16, ovf16, sum16} !== 20'h0 ||
          {busy1, done1, cout1, ovf1, sum1} !== 7'h0 ||
          {busy3, done3, cout3, ovf3, sum3} !== 7'h0) begin
        errs++;
        $display("FAIL reset_hold b16=%b d16=%b s16=%h b1=%b d1=%b s1=%h b3=%b d3=%b s3=%h want all 0",
                 busy16, done16, sum16, busy1, done1, sum1,
                 busy3, done3, sum3);
      end
    end
    s16 = 1'b0; s1 = 1'b0; s3 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    run16(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run16(16'h0005, 16'h0007, 1'b1, 1'b1);
    run16(16'h0007, 16'h0005, 1'b0, 1'b1);
    run16(16'h8000, 16'h0001, 1'b0, 1'b1);
  endtask

  task automatic test_start_during_run();
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0;
    s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b1; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if ({done16, sum16, cout16, ovf16} !== {1'b1, 16'h0100, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL start_in_run done=%b sum=%h cout=%b ovf=%b want done=1 sum=0100 cout=0 ovf=0",
               done16, sum16, cout16, ovf16);
    end
    @(negedge clk);
    vecs++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      errs++;
      $display("FAIL start_in_run_queued busy=%b done=%b want 0 0",
               busy16, done16);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      s16 = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        vecs++;
        if (done16 !== 1'b0 || busy16 !== 1'b0) begin
          errs++;
          $display("FAIL idle_gap busy=%b done=%b want 0 0", busy16, done16);
        end
      end
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_run();
    run16(16'h1234, 16'h1111, 1'b0, 1'b0);
    a16 = 16'hF0F0; b16 = 16'h0F0F; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy16, done16, cout16, ovf16, sum16} !== 20'h0) begin
      errs++;
      $display("FAIL reset_async busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy16, done16, sum16, cout16, ovf16);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (done16 !== 1'b0 || busy16 !== 1'b0 || sum16 !== 16'h0) begin
        errs++;
        $display("FAIL reset_no_done busy=%b done=%b sum=%h want 0 0 0",
                 busy16, done16, sum16);
      end
    end
    rst_n = 1'b1;
    run16(16'h4321, 16'h0FFF, 1'b1, 1'b0);
  endtask

  task automatic test_sweep();
    for (int sel = 0; sel < 2; sel++) begin
      int steps;
      steps = (sel == 1) ? 1 : 3;
      for (int v = 0; v < 256; v++) begin
        logic [7:0] vv;
        longint es;
        bit ec, eo, dn;
        int cnt;
        logic [2:0] gs;
        logic gc, go;
        vv = 8'(v);
        model(3, longint'(vv[2:0]), longint'(vv[5:3]), vv[6], vv[7],
              es, ec, eo);
        a3 = vv[2:0]; b3 = vv[5:3]; cin3 = vv[6]; sub3 = vv[7];
        if (sel == 1) s3 = 1'b1;
        else          s1 = 1'b1;
        cnt = 0;
        dn = 1'b0;
        while (!dn && cnt < 8) begin
          @(negedge clk);
          cnt++;
          s1 = 1'b0; s3 = 1'b0;
          dn = (sel == 1) ? done3 : done1;
        end
        gs = (sel == 1) ? sum3 : sum1;
        gc = (sel == 1) ? cout3 : cout1;
        go = (sel == 1) ? ovf3 : ovf1;
        vecs++;
        if (cnt != steps + 1) begin
          errs++;
          $display("FAIL sweep_latency chunk=%0d v=%0d got %0d cycles want %0d",
                   (sel == 1) ? 3 : 1, v, cnt, steps + 1);
        end
        vecs++;
        if ({gc, go, gs} !== {ec, eo, es[2:0]}) begin
          errs++;
          $display("FAIL sweep_result chunk=%0d a=%0d b=%0d cin=%b sub=%b got sum=%0d cout=%b ovf=%b want sum=%0d cout=%b ovf=%b",
                   (sel == 1) ? 3 : 1, vv[2:0], vv[5:3], vv[6], vv[7],
                   gs, gc, go, es[2:0], ec, eo);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    s16 = 1'b0; s1 = 1'b0; s3 = 1'b0;
    sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
    sub3 = 1'b0; cin3 = 1'b0; a3 = '0; b3 = '0;
    test_reset();
    test_directed();
    test_start_during_run();
    test_random();
    test_reset_mid_run();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
